led_pattern_sequencer: RTL and testbench

//   Steps the LED controller's PWM datapath through a programmable sequence of brightness values.

---
 rtl/led_pattern_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Steps a PWM channel through a programmable table of duty values over a valid/ready handshake.
// Define LED_SEQ_LOOP_EN to wrap back to step 0 after the last step instead of finishing.
module led_pattern_sequencer #(
   parameter int N_STEPS = 8,
   parameter int DATA_W  = 8,
   parameter int PER_W   = 16,
   localparam int AW     = $clog2(N_STEPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   input  logic [AW-1:0]     cfg_len,
   input  logic [PER_W-1:0]  cfg_period,
   input  logic              start,
   input  logic              stop,
   output logic              pwm_valid,
   output logic [DATA_W-1:0] pwm_duty,
   input  logic              pwm_ready,
   output logic              busy,
   output logic [AW-1:0]     step_idx,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem_q [N_STEPS];
   logic [DATA_W-1:0] mem_d [N_STEPS];
   logic [AW-1:0]     len_q, len_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [PER_W-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] duty_q, duty_d;
   logic              done_q, done_d;

   // Table writes are accepted every cycle, regardless of enable or run state.
   always_comb begin
      for (int i = 0; i < N_STEPS; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (cfg_we) begin
         mem_d[cfg_addr] = cfg_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      per_d   = per_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      duty_d  = duty_q;
      done_d  = done_q;
      if (ena) begin
         done_d = 1'b0;
         if (stop) begin
            state_d = IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_d = LOAD;
                     idx_d   = '0;
                     duty_d  = mem_q[0];
                     len_d   = cfg_len;
                     per_d   = cfg_period;
                  end
               end
               LOAD: begin
                  if (pwm_ready) begin
                     state_d = HOLD;
                     // A zero period behaves as one cycle of hold.
                     cnt_d   = (per_q == '0) ? '0 : per_q - PER_W'(1);
                  end
               end
               HOLD: begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - PER_W'(1);
                  end else if (idx_q != len_q) begin
                     state_d = LOAD;
                     idx_d   = idx_q + AW'(1);
                     duty_d  = mem_q[idx_q + AW'(1)];
                  end else begin
`ifdef LED_SEQ_LOOP_EN
                     state_d = LOAD;
                     idx_d   = '0;
                     duty_d  = mem_q[0];
`else
                     state_d = IDLE;
                     done_d  = 1'b1;
`endif
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         for (int i = 0; i < N_STEPS; i++) begin
            mem_q[i] <= '0;
         end
         len_q  <= '0;
         per_q  <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
         duty_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < N_STEPS; i++) begin
            mem_q[i] <= mem_d[i];
         end
         len_q  <= len_d;
         per_q  <= per_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         duty_q <= duty_d;
         done_q <= done_d;
      end
   end

   assign pwm_valid = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign pwm_duty  = duty_q;
   assign step_idx  = idx_q;
   assign done      = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized bench for led_pattern_sequencer against a timeline model of each run.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;
   localparam int N  = 8;
   localparam int DW = 8;
   localparam int PW = 16;
   localparam int AW = 3;
   localparam int MAXA = 1024;
   localparam int MAXK = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [DW-1:0] cfg_wdata = '0;
   logic [AW-1:0] cfg_len = '0;
   logic [PW-1:0] cfg_period = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pwm_valid;
   logic [DW-1:0] pwm_duty;
   logic          pwm_ready = 1'b0;
   logic          busy;
   logic [AW-1:0] step_idx;
   logic          done;

   led_pattern_sequencer #(.N_STEPS(N), .DATA_W(DW), .PER_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_len(cfg_len), .cfg_period(cfg_period),
      .start(start), .stop(stop), .pwm_valid(pwm_valid), .pwm_duty(pwm_duty),
      .pwm_ready(pwm_ready), .busy(busy), .step_idx(step_idx), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int model_mem [N];
   bit rdy_arr [MAXA];
   int t_arr [MAXK];
   int h_arr [MAXK];
   int run_no = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, pwm_valid, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_duty"}, pwm_duty, 0);
      check_val({tag, "_idx"}, step_idx, 0);
   endtask

   // Caller is positioned 1ns after a rising edge.
   task automatic write_mem(input int a, input int d);
      cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = DW'(d);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      model_mem[a] = d;
   endtask

   // One run: abstract time advances only on enabled edges; step k is offered from t_arr[k]
   // until its handshake h_arr[k], then held max(period,1) cycles before the next offer.
   task automatic run_seq(input int len, input int per, input int ready_pct,
                          input int ena_pct, input int stop_in);
      int p, nk, done_t, a_end, a, s, k, ref_a, guard, errs0;
      bit loop_mode, en, cut, e_valid, e_busy, e_done;
      int e_duty, e_idx;
`ifdef LED_SEQ_LOOP_EN
      loop_mode = 1'b1;
`else
      loop_mode = 1'b0;
`endif
      p  = (per == 0) ? 1 : per;
      s  = stop_in;
      nk = loop_mode ? MAXK : len + 1;
      for (int i = 0; i < MAXA; i++)
         rdy_arr[i] = ($urandom_range(99) < ready_pct) || (i % 8 == 0);
      t_arr[0] = 1;
      for (int i = 0; i < nk; i++) begin
         h_arr[i] = t_arr[i];
         while (!rdy_arr[h_arr[i]]) h_arr[i]++;
         if (i + 1 < nk) t_arr[i + 1] = h_arr[i] + 1 + p;
      end
      done_t = h_arr[nk - 1] + 1 + p;
      if (loop_mode && s < 0) s = 40;
      if (!loop_mode && s >= done_t) s = -1;
      a_end = (s >= 0) ? s + 2 : done_t + 2;
      errs0 = n_checks - n_pass;

      cfg_len = AW'(len); cfg_period = PW'(per); ena = 1'b1; stop = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 1; guard = 0;
      while (a <= a_end && guard < 4000) begin
         guard++;
         cut   = (s >= 0) && (a > s);
         ref_a = cut ? s : a;
         k = 0;
         for (int i = 0; i < nk; i++) if (t_arr[i] <= ref_a) k = i;
         e_idx  = k % (len + 1);
         e_duty = model_mem[e_idx];
         e_valid = !cut && (ref_a <= h_arr[k]);
         e_busy  = !cut && (loop_mode || ref_a < done_t);
         e_done  = !cut && !loop_mode && (ref_a == done_t);

         en = ($urandom_range(99) >= ena_pct);
         ena = en;
         pwm_ready = rdy_arr[a];
         stop = en && (a == s);
         start = e_busy && (a != s) && ($urandom_range(3) == 0);
         cfg_len = AW'($urandom_range(7));
         cfg_period = PW'($urandom_range(9));
         @(negedge clk);
         check_val("valid", pwm_valid, e_valid);
         check_val("busy", busy, e_busy);
         check_val("done", done, e_done);
         check_val("duty", pwm_duty, e_duty);
         check_val("idx", step_idx, e_idx);
         @(posedge clk); #1;
         if (en) a++;
      end
      check_val("run_bound", int'(guard < 4000), 1);
      start = 1'b0; stop = 1'b0; ena = 1'b1; pwm_ready = 1'b0;
      run_no++;
      $display("run %0d: len=%0d period=%0d ready%%=%0d ena_off%%=%0d stop=%0d end=%0d errors=%0d",
               run_no, len, per, ready_pct, ena_pct, s, a_end, (n_checks - n_pass) - errs0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) model_mem[i] = 0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      ena = 1'b1;

      write_mem(0, 10); write_mem(1, 80); write_mem(2, 255);
      run_seq(2, 4, 100, 0, -1);   // basic three-step sequence
      run_seq(2, 3, 40, 0, -1);    // backpressure
      run_seq(2, 4, 100, 0, 8);    // abort during HOLD of step 1
      check_val("abort_duty", pwm_duty, 80);

      // start and stop together leave the sequencer idle
      start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      @(negedge clk);
      check_val("startstop_busy", busy, 0);
      check_val("startstop_valid", pwm_valid, 0);
      @(posedge clk); #1;

      run_seq(3, 0, 100, 0, -1);   // period 0 acts as 1
      run_seq(2, 5, 100, 30, -1);  // random enable gaps

      for (int r = 0; r < 12; r++) begin
         int len, per, stp;
         for (int i = 0; i < N; i++) write_mem(i, $urandom_range(255));
         len = $urandom_range(7);
         per = $urandom_range(6);
         stp = ($urandom_range(2) == 0) ? $urandom_range(1, 30) : -1;
         run_seq(len, per, $urandom_range(50, 100), $urandom_range(0, 30), stp);
      end

      // asynchronous reset while offering a step
      write_mem(0, 123);
      pwm_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val("preload_valid", pwm_valid, 1);
      check_val("preload_duty", pwm_duty, 123);
      #2.5;
      rst_n = 1'b0;
      #0.5;
      check_all_zero("async_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) model_mem[i] = 0;
      run_seq(7, 1, 100, 0, -1);   // cleared memory presents duty 0

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
